knn_seq_ctrl: RTL and testbench

//  Sequencer for the knn solver array: clears it, loads one test point per solver, streams a job of training points, then reads back the HW_K results per solver.

---
 rtl/knn_seq_ctrl_pkg.sv | 20 ++
 rtl/knn_rd_buf.sv | 49 ++++
 rtl/knn_seq_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_knn_seq_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_seq_ctrl_pkg.sv
// Shared types and helpers for the knn solver-array sequencer.
package knn_seq_ctrl_pkg;

    localparam int unsigned SelW = 16;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StLoad,
        StSettle,
        StStream,
        StRead,
        StFlush
    } state_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/knn_rd_buf.sv
// One-entry valid/ready holding register for knn result words.
module knn_rd_buf #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [Width-1:0] data_i,
    output logic             can_load_o,
    output logic             valid_o,
    output logic [Width-1:0] data_o,
    input  logic             ready_i
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;

    // A new word may enter when empty or when the held word leaves this cycle.
    assign can_load_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr_i) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (load_i && can_load_o) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/knn_seq_ctrl.sv
// Sequencer for the knn solver array: clear, load test points, stream training
// points, then read back HwK results per solver through a one-entry buffer.
module knn_seq_ctrl
    import knn_seq_ctrl_pkg::*;
#(
    parameter int unsigned HwK      = 4,
    parameter int unsigned NSolvers = 2,
    parameter int unsigned DataW    = 32,
    parameter int unsigned OutW     = 16,
    parameter int unsigned CntW     = 16,
    parameter int unsigned SolvW    = clog2_min1(NSolvers),
    parameter int unsigned IdxW     = clog2_min1(HwK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CntW-1:0]  n_train_i,
    input  logic             test_valid_i,
    input  logic [DataW-1:0] test_data_i,
    output logic             test_ready_o,
    input  logic             train_valid_i,
    input  logic [DataW-1:0] train_data_i,
    output logic             train_ready_o,
    output logic             res_valid_o,
    output logic [OutW-1:0]  res_data_o,
    output logic [SolvW-1:0] res_solver_o,
    output logic [IdxW-1:0]  res_idx_o,
    output logic             res_last_o,
    input  logic             res_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             knn_valid_o,
    output logic             knn_done_o,
    output logic [SelW-1:0]  knn_sel_o,
    output logic [SelW-1:0]  knn_solver_sel_o,
    output logic [DataW-1:0] knn_data_1_o,
    output logic [DataW-1:0] knn_data_2_o,
    input  logic [OutW-1:0]  knn_data_out_i
);

    localparam int unsigned BufW = 1 + SolvW + IdxW + OutW;

    state_e             state_q;
    logic [CntW-1:0]    n_train_q, train_cnt_q;
    logic [SolvW-1:0]   solver_q, knn_solver_sel_q;
    logic [IdxW-1:0]    knn_sel_q;
    logic               knn_valid_q, knn_done_q;
    logic               test_ready_q, train_ready_q, done_q;
    logic [DataW-1:0]   knn_data_1_q;

    logic               test_acc, train_acc, last_word, rd_cap, buf_can_load;
    logic [BufW-1:0]    buf_in, buf_out;

    assign test_acc  = test_valid_i && test_ready_q;
    assign train_acc = train_valid_i && train_ready_q;
    assign last_word = (knn_solver_sel_q == SolvW'(NSolvers - 1)) &&
                       (knn_sel_q == IdxW'(HwK - 1));
    assign rd_cap    = (state_q == StRead) && buf_can_load;
    assign buf_in    = {last_word, knn_solver_sel_q, knn_sel_q, knn_data_out_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            n_train_q        <= '0;
            train_cnt_q      <= '0;
            solver_q         <= '0;
            knn_solver_sel_q <= '0;
            knn_sel_q        <= '0;
            knn_valid_q      <= 1'b0;
            knn_done_q       <= 1'b1;
            test_ready_q     <= 1'b0;
            train_ready_q    <= 1'b0;
            done_q           <= 1'b0;
            knn_data_1_q     <= '0;
        end else if (abort_i) begin
            state_q          <= StIdle;
            knn_valid_q      <= 1'b0;
            knn_done_q       <= 1'b1;
            test_ready_q     <= 1'b0;
            train_ready_q    <= 1'b0;
            done_q           <= 1'b0;
            knn_sel_q        <= '0;
            knn_solver_sel_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        n_train_q   <= n_train_i;
                        train_cnt_q <= '0;
                        solver_q    <= '0;
                        knn_valid_q <= 1'b1;
                        knn_done_q  <= 1'b1;
                        state_q     <= StInit;
                    end
                end
                StInit: begin
                    knn_valid_q      <= 1'b0;
                    knn_done_q       <= 1'b0;
                    knn_solver_sel_q <= '0;
                    test_ready_q     <= 1'b1;
                    state_q          <= StLoad;
                end
                StLoad: begin
                    if (test_acc) begin
                        knn_data_1_q     <= test_data_i;
                        knn_solver_sel_q <= solver_q;
                        if (solver_q == SolvW'(NSolvers - 1)) begin
                            test_ready_q <= 1'b0;
                            state_q      <= StSettle;
                        end else begin
                            solver_q <= solver_q + 1'b1;
                        end
                    end
                end
                StSettle: begin
                    // Holding valid low here lets the solver latch the final test point.
                    if (n_train_q == '0) begin
                        knn_done_q       <= 1'b1;
                        knn_solver_sel_q <= '0;
                        knn_sel_q        <= '0;
                        state_q          <= StRead;
                    end else begin
                        train_ready_q <= 1'b1;
                        state_q       <= StStream;
                    end
                end
                StStream: begin
                    if (train_acc) begin
                        if (train_cnt_q != '1) begin
                            train_cnt_q <= train_cnt_q + 1'b1;
                        end
                        if (train_cnt_q == n_train_q - 1'b1) begin
                            train_ready_q    <= 1'b0;
                            knn_done_q       <= 1'b1;
                            knn_solver_sel_q <= '0;
                            knn_sel_q        <= '0;
                            state_q          <= StRead;
                        end
                    end
                end
                StRead: begin
                    if (rd_cap) begin
                        if (last_word) begin
                            state_q <= StFlush;
                        end else if (knn_sel_q == IdxW'(HwK - 1)) begin
                            knn_sel_q        <= '0;
                            knn_solver_sel_q <= knn_solver_sel_q + 1'b1;
                        end else begin
                            knn_sel_q <= knn_sel_q + 1'b1;
                        end
                    end
                end
                StFlush: begin
                    if (res_valid_o && res_ready_i) begin
                        done_q           <= 1'b1;
                        knn_sel_q        <= '0;
                        knn_solver_sel_q <= '0;
                        state_q          <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    knn_rd_buf #(
        .Width (BufW)
    ) u_rd_buf (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (abort_i),
        .load_i     (rd_cap),
        .data_i     (buf_in),
        .can_load_o (buf_can_load),
        .valid_o    (res_valid_o),
        .data_o     (buf_out),
        .ready_i    (res_ready_i)
    );

    assign {res_last_o, res_solver_o, res_idx_o, res_data_o} = buf_out;

    // Training points pass straight through so the stream runs at full rate.
    assign knn_valid_o      = knn_valid_q || train_acc;
    assign knn_data_2_o     = train_ready_q ? train_data_i : '0;
    assign knn_done_o       = knn_done_q;
    assign knn_data_1_o     = knn_data_1_q;
    assign knn_sel_o        = SelW'(knn_sel_q);
    assign knn_solver_sel_o = SelW'(knn_solver_sel_q);
    assign test_ready_o     = test_ready_q;
    assign train_ready_o    = train_ready_q;
    assign busy_o           = (state_q != StIdle);
    assign done_o           = done_q;

endmodule

// File: tb/tb_knn_seq_ctrl.sv
// Self-checking bench for knn_seq_ctrl with a behavioural knn solver model.
module tb_knn_seq_ctrl;

    typedef struct {
        logic [15:0] data;
        logic        solver;
        logic [1:0]  idx;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0;
    logic [15:0] n_train = '0;
    logic        test_valid = 1'b0, train_valid = 1'b0, res_ready = 1'b0;
    logic [31:0] test_data = '0, train_data = '0;
    logic        test_ready, train_ready, res_valid, res_last, res_solver;
    logic [15:0] res_data;
    logic [1:0]  res_idx;
    logic        busy, done, knn_valid, knn_done;
    logic [15:0] knn_sel, knn_solver_sel, knn_data_out;
    logic [31:0] knn_data_1, knn_data_2;

    int   checks = 0;
    int   errors = 0;
    int   kv_cnt = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];

    logic [31:0] m_test[2];
    logic [31:0] m_train[$];
    logic [15:0] m_res[2][4];
    logic        s_v, s_dn, s_ss;
    logic [31:0] s_d1, s_d2;

    always #5 clk = ~clk;

    knn_seq_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start),
        .abort_i          (abort),
        .n_train_i        (n_train),
        .test_valid_i     (test_valid),
        .test_data_i      (test_data),
        .test_ready_o     (test_ready),
        .train_valid_i    (train_valid),
        .train_data_i     (train_data),
        .train_ready_o    (train_ready),
        .res_valid_o      (res_valid),
        .res_data_o       (res_data),
        .res_solver_o     (res_solver),
        .res_idx_o        (res_idx),
        .res_last_o       (res_last),
        .res_ready_i      (res_ready),
        .busy_o           (busy),
        .done_o           (done),
        .knn_valid_o      (knn_valid),
        .knn_done_o       (knn_done),
        .knn_sel_o        (knn_sel),
        .knn_solver_sel_o (knn_solver_sel),
        .knn_data_1_o     (knn_data_1),
        .knn_data_2_o     (knn_data_2),
        .knn_data_out_i   (knn_data_out)
    );

    function automatic int unsigned absdiff(input int unsigned a, input int unsigned b);
        return (a > b) ? a - b : b - a;
    endfunction

    // k-th nearest point held by the model, 16'hFFFF when the slot is empty.
    function automatic logic [15:0] model_nearest(input logic [31:0] tp, input int k);
        bit used[64];
        int best;
        logic [15:0] r = 16'hFFFF;
        if (k >= m_train.size()) return 16'hFFFF;
        for (int j = 0; j < 64; j++) used[j] = 1'b0;
        for (int r_k = 0; r_k <= k; r_k++) begin
            best = -1;
            for (int i = 0; i < m_train.size(); i++)
                if (!used[i] && (best < 0 || absdiff(m_train[i], tp) < absdiff(m_train[best], tp)))
                    best = i;
            used[best] = 1'b1;
            r = m_train[best][15:0];
        end
        return r;
    endfunction

    // Expected k-th nearest among training points 3,6,...,3n.
    function automatic logic [15:0] exp_nearest(input int unsigned tp, input int n, input int k);
        bit used[64];
        int best;
        int unsigned pt = 0;
        if (k >= n) return 16'hFFFF;
        for (int j = 0; j < 64; j++) used[j] = 1'b0;
        for (int r_k = 0; r_k <= k; r_k++) begin
            best = -1;
            for (int i = 0; i < n; i++)
                if (!used[i] && (best < 0 ||
                    absdiff(3 * (i + 1), tp) < absdiff(3 * (best + 1), tp)))
                    best = i;
            used[best] = 1'b1;
            pt = 3 * (best + 1);
        end
        return pt[15:0];
    endfunction

    // Behavioural knn array: acts on the port values present at each rising edge.
    initial begin
        m_test[0] = '0;
        m_test[1] = '0;
        forever begin
            @(negedge clk);
            s_v  = knn_valid;
            s_dn = knn_done;
            s_ss = knn_solver_sel[0];
            s_d1 = knn_data_1;
            s_d2 = knn_data_2;
            @(posedge clk);
            if (!rst) begin
                if (s_v && s_dn) m_train.delete();
                else if (!s_v && !s_dn) m_test[s_ss] = s_d1;
                else if (s_v && !s_dn) m_train.push_back(s_d2);
            end
            #1;
            for (int s = 0; s < 2; s++)
                for (int k = 0; k < 4; k++) m_res[s][k] = model_nearest(m_test[s], k);
        end
    end

    assign knn_data_out = m_res[knn_solver_sel[0]][knn_sel[1:0]];

    // Scoreboard and stall-stability monitor.
    initial begin
        exp_t e;
        logic        prev_stall = 1'b0;
        logic [19:0] held = '0;
        forever begin
            @(negedge clk);
            if (knn_valid && !knn_done) kv_cnt++;
            if (done) done_cnt++;
            if (prev_stall) begin
                checks++;
                if (!res_valid || {res_last, res_solver, res_idx, res_data} !== held) begin
                    errors++;
                    $display("FAIL stall_stable: got v=%0b %0h required v=1 %0h",
                             res_valid, {res_last, res_solver, res_idx, res_data}, held);
                end
            end
            prev_stall = res_valid && !res_ready && !rst;
            held = {res_last, res_solver, res_idx, res_data};
            if (res_valid && res_ready && !rst) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL result_extra: got %0h required no word", res_data);
                end else begin
                    e = exp_q.pop_front();
                    if (res_data !== e.data || res_solver !== e.solver ||
                        res_idx !== e.idx || res_last !== e.last) begin
                        errors++;
                        $display("FAIL result: got d=%0d s=%0d i=%0d l=%0b required d=%0d s=%0d i=%0d l=%0b",
                                 res_data, res_solver, res_idx, res_last,
                                 e.data, e.solver, e.idx, e.last);
                    end
                end
            end
        end
    end

    task automatic run_job(input int unsigned tp0, input int unsigned tp1, input int n,
                           input bit toggle, input bit start_mid);
        exp_t e;
        int   kv0, d0, cyc, i;
        bit   acc;
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < 4; k++) begin
                e.data   = exp_nearest((s == 0) ? tp0 : tp1, n, k);
                e.solver = s[0];
                e.idx    = k[1:0];
                e.last   = (s == 1 && k == 3);
                exp_q.push_back(e);
            end
        kv0 = kv_cnt;
        d0  = done_cnt;
        res_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        n_train = n[15:0];
        @(posedge clk); #1;
        start = 1'b0;
        n_train = 16'd3;
        for (int s = 0; s < 2; s++) begin
            test_valid = 1'b1;
            test_data  = (s == 0) ? tp0 : tp1;
            cyc = 0;
            acc = 1'b0;
            while (!acc && cyc < 20) begin
                @(negedge clk);
                acc = test_ready;
                @(posedge clk); #1;
                cyc++;
            end
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL load_timeout: got no accept required accept of test %0d", s);
            end
        end
        test_valid = 1'b0;
        i = 0;
        cyc = 0;
        while (i < n && cyc < 1000) begin
            train_valid = (cyc % 3 == 0);
            train_data  = 3 * (i + 1);
            @(negedge clk);
            acc = train_valid && train_ready;
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
        end
        train_valid = 1'b0;
        checks++;
        if (i != n) begin
            errors++;
            $display("FAIL stream_timeout: got %0d accepts required %0d", i, n);
        end
        cyc = 0;
        while (done_cnt == d0 && cyc < 300) begin
            start = (start_mid && cyc == 2);
            if (start) n_train = 16'd7;
            if (start_mid && cyc < 5) res_ready = 1'b0;
            else if (toggle) res_ready = ~res_ready;
            else res_ready = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL done_pulses: got %0d required 1", done_cnt - d0);
        end
        checks++;
        if (kv_cnt - kv0 != n) begin
            errors++;
            $display("FAIL knn_valid_pulses: got %0d required %0d", kv_cnt - kv0, n);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL words_missing: got %0d left required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL job_end_idle: got busy=%0b res_valid=%0b required 0 0", busy, res_valid);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (knn_done !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got done_knn=%0b busy=%0b done=%0b required 1 0 0",
                     knn_done, busy, done);
        end
        checks++;
        if ({knn_valid, test_ready, train_ready, res_valid} !== 4'b0) begin
            errors++;
            $display("FAIL reset_handshake: got %b required 0000",
                     {knn_valid, test_ready, train_ready, res_valid});
        end
        checks++;
        if (knn_sel !== 16'd0 || knn_solver_sel !== 16'd0 || knn_data_1 !== 32'd0 ||
            knn_data_2 !== 32'd0) begin
            errors++;
            $display("FAIL reset_knn_bus: got sel=%0h ssel=%0h d1=%0h d2=%0h required 0",
                     knn_sel, knn_solver_sel, knn_data_1, knn_data_2);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_main_job();
        run_job(200, 50, 33, 1'b0, 1'b0);
    endtask

    task automatic test_res_ready_toggle();
        run_job(200, 50, 33, 1'b1, 1'b0);
    endtask

    task automatic test_zero_train();
        run_job(10, 20, 0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        int d0, cyc;
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        n_train = 16'd4;
        @(posedge clk); #1;
        start = 1'b0;
        test_valid = 1'b1;
        test_data = 32'd7;
        cyc = 0;
        while (test_ready !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        test_valid = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || test_ready !== 1'b0 || knn_done !== 1'b1 || knn_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_load: got busy=%0b trdy=%0b kdone=%0b kvalid=%0b required 0 0 1 0",
                     busy, test_ready, knn_done, knn_valid);
        end
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_beats_start: got busy=%0b required 0", busy);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d pulses required 0", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_stream();
        int cyc;
        @(posedge clk); #1;
        start = 1'b1;
        n_train = 16'd10;
        @(posedge clk); #1;
        start = 1'b0;
        for (int s = 0; s < 2; s++) begin
            test_valid = 1'b1;
            test_data = 32'd100 + s;
            cyc = 0;
            while (test_ready !== 1'b1 && cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            @(posedge clk); #1;
        end
        test_valid = 1'b0;
        train_valid = 1'b1;
        train_data = 32'd5;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (knn_done !== 1'b1 || knn_valid !== 1'b0 || busy !== 1'b0 || train_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stream: got kdone=%0b kvalid=%0b busy=%0b trdy=%0b required 1 0 0 0",
                     knn_done, knn_valid, busy, train_ready);
        end
        train_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        run_job(200, 50, 6, 1'b0, 1'b0);
    endtask

    task automatic test_start_during_read();
        run_job(30, 60, 9, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_read: got busy=%0b required 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_main_job();
        test_res_ready_toggle();
        test_zero_train();
        test_abort();
        test_reset_mid_stream();
        test_start_during_read();
        test_main_job();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

endmodule
